// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - parametrised UART transmitter with parity, stop-bit and busy options
module uart_tx_cfg #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 newd,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 donetx,
  output logic                 busy
);

  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int BW    = $clog2(DIV);
  localparam int CW    = $clog2(DATA_BITS + 1);
  localparam int NSTOP = (STOP_BITS == 2) ? 2 : 1;

  // Out-of-range PARITY values collapse to "none".
  localparam logic PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam logic PAR_ODD = (PARITY == 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(NSTOP - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 baud_tick;

  assign baud_tick = (baud_q == BAUD_LAST);

  // Next-state logic; tx/busy/donetx are computed one cycle ahead so the pins come straight from flops.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = baud_tick ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (newd) begin
          shreg_d = tx_data;
          par_d   = (^tx_data) ^ PAR_ODD;
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (baud_tick) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PAR_EN) begin
              state_d = S_PAR;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      S_PAR: begin
        if (baud_tick) begin
          state_d = S_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx     = tx_q;
  assign donetx = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - scoreboard bench for uart_tx_cfg across four configurations
module tb_uart_tx_cfg;

  localparam int DIV = 10;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          acc;
    bit          abort;
  } frame_t;

  logic       clk;
  logic       rst;
  logic [3:0] newd_a;
  logic [8:0] data_a [4];
  logic [3:0] tx_a;
  logic [3:0] done_a;
  logic [3:0] busy_a;

  int dbits_c [4] = '{8, 8, 8, 7};
  int par_c   [4] = '{0, 2, 1, 0};
  int stop_c  [4] = '{1, 1, 1, 2};

  frame_t exp_q [4][$];
  int     exp_done [4];
  int     done_cnt [4];
  int     cyc;
  int     checks;
  int     failures;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .newd(newd_a[0]), .tx_data(data_a[0][7:0]),
    .tx(tx_a[0]), .donetx(done_a[0]), .busy(busy_a[0]));
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .newd(newd_a[1]), .tx_data(data_a[1][7:0]),
    .tx(tx_a[1]), .donetx(done_a[1]), .busy(busy_a[1]));
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .newd(newd_a[2]), .tx_data(data_a[2][7:0]),
    .tx(tx_a[2]), .donetx(done_a[2]), .busy(busy_a[2]));
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .newd(newd_a[3]), .tx_data(data_a[3][6:0]),
    .tx(tx_a[3]), .donetx(done_a[3]), .busy(busy_a[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 4; k++) begin
      if (done_a[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, stop 1s.
  function automatic frame_t build(input int k, input logic [8:0] d, input int acc, input bit ab);
    frame_t f;
    int     n;
    logic   p;
    f.bits = '0;
    n = 1;
    p = 1'b0;
    for (int i = 0; i < dbits_c[k]; i++) begin
      f.bits[n] = d[i];
      p = p ^ d[i];
      n++;
    end
    if (par_c[k] != 0) begin
      f.bits[n] = (par_c[k] == 1) ? ~p : p;
      n++;
    end
    for (int s = 0; s < stop_c[k]; s++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.nbits = n;
    f.acc   = acc;
    f.abort = ab;
    return f;
  endfunction

  // acc is the cyc value seen at the first negedge after the accepting posedge.
  task automatic send(input int k, input logic [8:0] d, input bit ab);
    @(negedge clk);
    data_a[k] = d;
    newd_a[k] = 1'b1;
    exp_q[k].push_back(build(k, d, cyc + 1, ab));
    if (!ab) exp_done[k]++;
    @(negedge clk);
    newd_a[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((exp_q[k].size() != 0 || busy_a[k] !== 1'b0) && t < 3000);
    check_eq($sformatf("u%0d_idle_timeout", k), (t < 3000) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic monitor(input int k);
    frame_t      e;
    logic [15:0] got;
    int          unstable;
    bit          aborted;
    logic        first;
    int          start_cyc;
    forever begin
      @(negedge clk);
      if (!rst && busy_a[k] === 1'b1) begin
        start_cyc = cyc;
        if (exp_q[k].size() == 0) begin
          check_eq($sformatf("u%0d_unexpected_frame", k), 1, 0);
          while (busy_a[k] === 1'b1 && !rst) @(negedge clk);
          continue;
        end
        e = exp_q[k].pop_front();
        check_eq($sformatf("u%0d_start_latency", k), start_cyc, e.acc);
        got = '0;
        unstable = 0;
        aborted = 1'b0;
        first = 1'b0;
        for (int b = 0; b < e.nbits && !aborted; b++) begin
          for (int c = 0; c < DIV && !aborted; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
            end else begin
              if (c == 0) begin
                first = tx_a[k];
                got[b] = first;
              end else if (tx_a[k] !== first) begin
                unstable++;
              end
              if (busy_a[k] !== 1'b1 || done_a[k] !== 1'b0) unstable++;
            end
          end
        end
        if (aborted) begin
          check_eq($sformatf("u%0d_abort_expected", k), e.abort, 1);
          continue;
        end
        @(negedge clk);
        check_eq($sformatf("u%0d_frame_bits", k), got, e.bits);
        check_eq($sformatf("u%0d_bit_hold", k), unstable, 0);
        check_eq($sformatf("u%0d_done_pulse", k), done_a[k], 1);
        check_eq($sformatf("u%0d_busy_at_done", k), busy_a[k], 0);
        check_eq($sformatf("u%0d_idle_tx", k), tx_a[k], 1);
        check_eq($sformatf("u%0d_completed_not_abort", k), e.abort, 0);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      automatic int kk = k;
      fork
        monitor(kk);
      join_none
    end
  end

  initial begin
    int a1;
    checks = 0;
    failures = 0;
    cyc = 0;
    rst = 1'b1;
    newd_a = '0;
    for (int k = 0; k < 4; k++) begin
      data_a[k] = '0;
      exp_done[k] = 0;
      done_cnt[k] = 0;
    end
    repeat (4) @(negedge clk);
    check_eq("reset_tx", tx_a, 4'hf);
    check_eq("reset_busy", busy_a, 4'h0);
    check_eq("reset_done", done_a, 4'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 8N1 basic
    send(0, 9'h0A5, 1'b0);
    wait_idle(0);

    // parity variants and 7-bit / 2-stop
    send(1, 9'h0A5, 1'b0);
    send(2, 9'h0A5, 1'b0);
    send(3, 9'h055, 1'b0);
    wait_idle(1);
    send(1, 9'h007, 1'b0);
    wait_idle(1);
    wait_idle(2);
    wait_idle(3);

    // newd mid-frame is ignored
    send(0, 9'h0A5, 1'b0);
    repeat (38) @(negedge clk);
    data_a[0] = 9'h03C;
    newd_a[0] = 1'b1;
    @(negedge clk);
    newd_a[0] = 1'b0;
    wait_idle(0);
    repeat (20) @(negedge clk);

    // reset mid-frame
    send(0, 9'h0A5, 1'b1);
    repeat (33) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("abort_tx", tx_a[0], 1);
    check_eq("abort_busy", busy_a[0], 0);
    check_eq("abort_done", done_a[0], 0);
    repeat (150) @(negedge clk);
    check_eq("abort_no_late_done", done_cnt[0], exp_done[0]);
    send(0, 9'h05A, 1'b0);
    wait_idle(0);

    // back-to-back with newd held high
    @(negedge clk);
    data_a[0] = 9'h000;
    newd_a[0] = 1'b1;
    a1 = cyc + 1;
    exp_q[0].push_back(build(0, 9'h000, a1, 1'b0));
    exp_done[0]++;
    repeat (50) @(negedge clk);
    data_a[0] = 9'h0FF;
    exp_q[0].push_back(build(0, 9'h0FF, a1 + 10 * DIV + 1, 1'b0));
    exp_done[0]++;
    while (cyc < a1 + 10 * DIV + 1) @(negedge clk);
    newd_a[0] = 1'b0;
    wait_idle(0);

    repeat (20) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("u%0d_done_count", k), done_cnt[k], exp_done[k]);
      check_eq($sformatf("u%0d_queue_empty", k), exp_q[k].size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised UART transmitter; next generation of the team's fixed 8N1 transmitter.
- Adds configurable data width, optional odd/even parity, 1 or 2 stop bits and a `busy` status output.
- Timing comes from a baud-rate clock-enable counter on the single system clock. No derived clocks.
- Sits between a byte/word producer (FIFO or control FSM) and the serial `tx` pin.

Parameters:
- `CLK_FREQ`, 1000000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: serial bit rate. `DIV = CLK_FREQ/BAUD_RATE` (integer truncation) is the number of clk cycles per bit; `DIV` must be >= 2.
- `DATA_BITS`, 8: payload width, legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even. Any other value is treated as none.
- `STOP_BITS`, 1: 1 or 2. Any other value is treated as 1.

Ports:
- `clk`  input  1  system clock, all logic on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `newd`  input  1  request to send `tx_data`. Sampled only when `busy` = 0.
- `tx_data`  input  `DATA_BITS`  payload, captured in the accept cycle.
- `tx`  output  1  serial line, idle high, registered.
- `donetx`  output  1  one-cycle pulse on frame completion, registered.
- `busy`  output  1  high while a frame is in progress, registered.

Behaviour:
- **Reset** (`rst` = 1 at a clk edge):
  - State goes to IDLE.
  - `tx` = 1, `donetx` = 0, `busy` = 0.
  - Baud counter, bit counter and shift register are cleared.
  - Reset mid-frame aborts the frame immediately (`tx` high the next cycle). No `donetx` pulse.
- **States:** IDLE, START, DATA, PAR, STOP.
- **IDLE:**
  - Outputs: `tx` = 1, `busy` = 0.
  - If `newd` = 1 at edge T: latch `tx_data`, compute the parity bit, clear the baud counter, and go to START. From T+1, `busy` = 1 and `tx` = 0.
  - Accept-to-start latency is exactly 1 cycle.
- **Bit timing:**
  - Each serial bit is held for exactly `DIV` cycles.
  - The baud counter runs 0..`DIV`-1; the state/bit advances when the counter = `DIV`-1, then the counter wraps to 0.
- **Bit sequence:**
  - START: 1 bit of 0.
  - DATA: `DATA_BITS` bits, LSB first; the bit counter runs 0..`DATA_BITS`-1.
  - PAR: present only if `PARITY` != 0. Even parity = XOR of the data; odd parity = its inverse.
  - STOP: `STOP_BITS` bits of 1.
- **Frame length:**
  - `N = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS` bits.
  - The FSM returns to IDLE at cycle T+1+N·`DIV`. In that cycle `donetx` = 1 and `busy` = 0.
  - `donetx` is high for exactly 1 cycle.
- **Handshake:**
  - `newd` while `busy` = 1 is ignored; no queuing.
  - `tx_data` changes after the accept cycle do not affect the frame in flight.
  - `newd` high in the `donetx` cycle starts the next frame. Minimum inter-frame idle is therefore 1 cycle of `tx` = 1.
  - `newd` held high continuously sends back-to-back frames, re-sampling `tx_data` each time.
- **Widths:**
  - Baud counter is `$clog2(DIV)` bits.
  - Bit counter is `$clog2(DATA_BITS+1)` bits.
- **Other rules:**
  - No glitches on `tx`.
  - No combinational path from any input to any output.

Test Plan:
- **8N1 basic.** `CLK_FREQ`=1000000, `BAUD_RATE`=100000 (`DIV`=10), `PARITY`=0, `STOP_BITS`=1. Send 0xA5 → `tx` low for 10 cycles starting 1 cycle after accept; then 1,0,1,0,0,1,0,1 at 10 cycles each; then high for 10 cycles. `donetx` pulses once at accept+101; `busy` is high for cycles accept+1..accept+100.
- **Parity.** `PARITY`=2 with 0xA5 → parity bit 0, frame 110 cycles. `PARITY`=1 with 0xA5 → parity bit 1. `PARITY`=2 with 0x07 → parity bit 1.
- **Width/stop options.** `DATA_BITS`=7, `STOP_BITS`=2, `PARITY`=0. Send 0x55 → 7 data bits 1,0,1,0,1,0,1, then 20 cycles high; `donetx` at accept+101.
- **Busy rejection.** Pulse `newd` with 0x3C at accept+40, mid-frame of 0xA5 → only 0xA5 is transmitted; no second frame; exactly one `donetx`.
- **Reset mid-frame.** Assert `rst` for 1 cycle at accept+35 → `tx`=1, `busy`=0, `donetx`=0 the next cycle, and no pulse later. A new `newd` afterwards sends a clean frame.
- **Back-to-back.** Hold `newd`=1, `tx_data`=0x00 then 0xFF (change during the first frame) → two frames 0x00 and 0xFF separated by exactly 1 idle-high cycle; two `donetx` pulses 101 cycles apart.
